// File: rtl/spu_writeback.sv
// SPU writeback stage: merges even/odd pipe results onto the single register-file
// write port in program order, buffering the surplus and forwarding pending values.
module spu_writeback #(
    parameter int WIDTH   = 128,
    parameter int REGBITS = 7,
    parameter int DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   even_valid,
    input  logic [REGBITS-1:0]     even_rt,
    input  logic [WIDTH-1:0]       even_data,
    input  logic                   odd_valid,
    input  logic [REGBITS-1:0]     odd_rt,
    input  logic [WIDTH-1:0]       odd_data,
    input  logic [REGBITS-1:0]     fwd_ra,
    output logic                   regwrite,
    output logic [REGBITS-1:0]     wa,
    output logic [WIDTH-1:0]       wd,
    output logic                   fwd_hit,
    output logic [WIDTH-1:0]       fwd_data,
    output logic                   stall,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow_err
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [REGBITS-1:0] buf_rt   [DEPTH];
    logic [WIDTH-1:0]   buf_data [DEPTH];
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      wr_ptr_p1;

    logic               ev_ok;
    logic               ov_ok;
    logic               have_head;
    logic               ret_v;
    logic [REGBITS-1:0] ret_rt;
    logic [WIDTH-1:0]   ret_data;
    logic               push0_v;
    logic [REGBITS-1:0] push0_rt;
    logic [WIDTH-1:0]   push0_data;
    logic               push1_v;
    logic [1:0]         n_push;

    assign stall     = (fifo_count == FULL);
    assign ev_ok     = even_valid & ~stall;
    assign ov_ok     = odd_valid & ~stall;
    assign have_head = (fifo_count != '0);
    assign wr_ptr_p1 = wr_ptr + PW'(1);
    assign n_push    = {1'b0, push0_v} + {1'b0, push1_v};

    // Oldest candidate (head, then even, then odd) retires; the rest queue in order.
    always_comb begin
        ret_v      = 1'b0;
        ret_rt     = '0;
        ret_data   = '0;
        push0_v    = 1'b0;
        push0_rt   = '0;
        push0_data = '0;
        push1_v    = 1'b0;
        if (have_head) begin
            ret_v      = 1'b1;
            ret_rt     = buf_rt[rd_ptr];
            ret_data   = buf_data[rd_ptr];
            push0_v    = ev_ok | ov_ok;
            push0_rt   = ev_ok ? even_rt   : odd_rt;
            push0_data = ev_ok ? even_data : odd_data;
            push1_v    = ev_ok & ov_ok;
        end else begin
            ret_v      = ev_ok | ov_ok;
            ret_rt     = ev_ok ? even_rt   : odd_rt;
            ret_data   = ev_ok ? even_data : odd_data;
            push0_v    = ev_ok & ov_ok;
            push0_rt   = odd_rt;
            push0_data = odd_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regwrite     <= 1'b0;
            wa           <= '0;
            wd           <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            fifo_count   <= '0;
            overflow_err <= 1'b0;
        end else begin
            regwrite <= ret_v;
            if (ret_v) begin
                wa <= ret_rt;
                wd <= ret_data;
            end
            if (have_head)
                rd_ptr <= rd_ptr + PW'(1);
            wr_ptr     <= wr_ptr + PW'(n_push);
            fifo_count <= fifo_count + (PW+1)'(n_push) - (PW+1)'(have_head);
            if (stall && (even_valid || odd_valid))
                overflow_err <= 1'b1;
        end
    end

    // Storage needs no reset: entries are only ever read below the occupancy count.
    always_ff @(posedge clk) begin
        if (push0_v) begin
            buf_rt[wr_ptr]   <= push0_rt;
            buf_data[wr_ptr] <= push0_data;
        end
        if (push1_v) begin
            buf_rt[wr_ptr_p1]   <= odd_rt;
            buf_data[wr_ptr_p1] <= odd_data;
        end
    end

    // Walk oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        logic [PW-1:0] idx;
        idx      = '0;
        fwd_hit  = regwrite && (wa == fwd_ra);
        fwd_data = fwd_hit ? wd : '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (((PW+1)'(i) < fifo_count) && (buf_rt[idx] == fwd_ra)) begin
                fwd_hit  = 1'b1;
                fwd_data = buf_data[idx];
            end
        end
    end

endmodule

// File: tb/tb_spu_writeback.sv
// Bench for spu_writeback: directed scenarios plus random traffic, all checked
// against a queue-based model of the pending-result stream.
module tb_spu_writeback;

    localparam int WIDTH   = 128;
    localparam int REGBITS = 7;
    localparam int DEPTH   = 4;

    logic               clk;
    logic               rst_n;
    logic               even_valid;
    logic [REGBITS-1:0] even_rt;
    logic [WIDTH-1:0]   even_data;
    logic               odd_valid;
    logic [REGBITS-1:0] odd_rt;
    logic [WIDTH-1:0]   odd_data;
    logic [REGBITS-1:0] fwd_ra;
    logic               regwrite;
    logic [REGBITS-1:0] wa;
    logic [WIDTH-1:0]   wd;
    logic               fwd_hit;
    logic [WIDTH-1:0]   fwd_data;
    logic               stall;
    logic [2:0]         fifo_count;
    logic               overflow_err;

    spu_writeback #(.WIDTH(WIDTH), .REGBITS(REGBITS), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .even_valid(even_valid), .even_rt(even_rt), .even_data(even_data),
        .odd_valid(odd_valid), .odd_rt(odd_rt), .odd_data(odd_data),
        .fwd_ra(fwd_ra),
        .regwrite(regwrite), .wa(wa), .wd(wd),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .stall(stall), .fifo_count(fifo_count), .overflow_err(overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [REGBITS-1:0] rt;
        logic [WIDTH-1:0]   d;
    } ent_t;

    // Model: mq holds every accepted-but-not-yet-written result, oldest first.
    ent_t               mq[$];
    logic               m_rw;
    logic [REGBITS-1:0] m_wa;
    logic [WIDTH-1:0]   m_wd;
    logic               m_ovf;
    logic [WIDTH:0]     exp_f;

    function automatic void model_reset();
        mq.delete();
        m_rw  = 1'b0;
        m_wa  = '0;
        m_wd  = '0;
        m_ovf = 1'b0;
    endfunction

    function automatic void model_step();
        ent_t e;
        if (mq.size() == DEPTH && (even_valid || odd_valid)) begin
            m_ovf = 1'b1;
        end else begin
            if (even_valid) begin e.rt = even_rt; e.d = even_data; mq.push_back(e); end
            if (odd_valid)  begin e.rt = odd_rt;  e.d = odd_data;  mq.push_back(e); end
        end
        if (mq.size() > 0) begin
            e    = mq.pop_front();
            m_rw = 1'b1;
            m_wa = e.rt;
            m_wd = e.d;
        end else begin
            m_rw = 1'b0;
        end
    endfunction

    function automatic logic [WIDTH:0] model_fwd(input logic [REGBITS-1:0] ra);
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].rt == ra) return {1'b1, mq[i].d};
        if (m_rw && m_wa == ra) return {1'b1, m_wd};
        return '0;
    endfunction

    function automatic logic [WIDTH-1:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic drive(input logic ev, input logic [REGBITS-1:0] ert, input logic [WIDTH-1:0] ed,
                         input logic ov, input logic [REGBITS-1:0] ort, input logic [WIDTH-1:0] od,
                         input logic [REGBITS-1:0] ra);
        even_valid = ev; even_rt = ert; even_data = ed;
        odd_valid  = ov; odd_rt  = ort; odd_data  = od;
        fwd_ra     = ra;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        #12;
        total++;
        if ({regwrite, wa, wd, fifo_count, overflow_err, stall} !== '0) begin
            bad++;
            $display("FAIL reset_init: got rw=%0b wa=%0d wd=%h cnt=%0d ovf=%0b stall=%0b, want all 0",
                     regwrite, wa, wd, fifo_count, overflow_err, stall);
        end
        model_reset();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive(1, 7'(2*c + 20), rnd128(), 1, 7'(2*c + 21), rnd128(), 7'(20));
            tick();
        end
        total++;
        if (fifo_count !== 3'd3) begin
            bad++;
            $display("FAIL reset_prefill: count=%0d want 3", fifo_count);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({regwrite, wa, wd, fifo_count, overflow_err, stall, fwd_hit, fwd_data} !== '0) begin
            bad++;
            $display("FAIL reset_async: got rw=%0b wa=%0d wd=%h cnt=%0d ovf=%0b stall=%0b hit=%0b fd=%h, want all 0",
                     regwrite, wa, wd, fifo_count, overflow_err, stall, fwd_hit, fwd_data);
        end
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        tick();
        total++;
        if ({stall, fifo_count, regwrite} !== '0) begin
            bad++;
            $display("FAIL reset_release: stall=%0b cnt=%0d rw=%0b, want 0 0 0", stall, fifo_count, regwrite);
        end
    endtask

    task automatic test_single();
        for (int c = 0; c < 3; c++) begin
            if (c == 0) drive(1, 7'd5, 128'hA5, 0, 0, 0, 7'd5);
            else        drive(0, 0, 0, 0, 0, 0, 7'd5);
            #1;
            exp_f = model_fwd(fwd_ra);
            total++;
            if ({stall, fwd_hit, fwd_data} !== {mq.size() == DEPTH, exp_f}) begin
                bad++;
                $display("FAIL single_comb c=%0d: stall/hit/fd=%0b/%0b/%h want %0b/%h",
                         c, stall, fwd_hit, fwd_data, mq.size() == DEPTH, exp_f);
            end
            tick();
            total++;
            if ({regwrite, wa, wd, fifo_count, overflow_err} !== {m_rw, m_wa, m_wd, 3'(mq.size()), m_ovf}) begin
                bad++;
                $display("FAIL single_seq c=%0d: rw=%0b wa=%0d wd=%h cnt=%0d ovf=%0b want %0b %0d %h %0d %0b",
                         c, regwrite, wa, wd, fifo_count, overflow_err, m_rw, m_wa, m_wd, mq.size(), m_ovf);
            end
            total++;
            if (c == 0 && {regwrite, wa, wd} !== {1'b1, 7'd5, 128'hA5}) begin
                bad++;
                $display("FAIL single_write: rw=%0b wa=%0d wd=%h want 1 5 a5", regwrite, wa, wd);
            end else if (c == 1 && regwrite !== 1'b0) begin
                bad++;
                $display("FAIL single_idle: rw=%0b want 0", regwrite);
            end
        end
    endtask

    task automatic test_dual_burst();
        int peak = 0;
        for (int c = 0; c < 8; c++) begin
            if (c < 4) drive(1, 7'(2*c + 1), rnd128(), 1, 7'(2*c + 2), rnd128(), 7'($urandom_range(1, 8)));
            else       drive(0, 0, 0, 0, 0, 0, 7'($urandom_range(1, 8)));
            #1;
            exp_f = model_fwd(fwd_ra);
            total++;
            if ({stall, fwd_hit, fwd_data} !== {mq.size() == DEPTH, exp_f}) begin
                bad++;
                $display("FAIL burst_comb c=%0d: stall/hit/fd=%0b/%0b/%h want %0b/%h",
                         c, stall, fwd_hit, fwd_data, mq.size() == DEPTH, exp_f);
            end
            tick();
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
            total++;
            if ({regwrite, wa, wd, fifo_count, overflow_err} !== {m_rw, m_wa, m_wd, 3'(mq.size()), m_ovf}) begin
                bad++;
                $display("FAIL burst_seq c=%0d: rw=%0b wa=%0d wd=%h cnt=%0d want %0b %0d %h %0d",
                         c, regwrite, wa, wd, fifo_count, m_rw, m_wa, m_wd, mq.size());
            end
            total++;
            if (regwrite !== 1'b1 || wa !== 7'(c + 1)) begin
                bad++;
                $display("FAIL burst_order c=%0d: rw=%0b wa=%0d want 1 %0d", c, regwrite, wa, c + 1);
            end
            if (c == 3) begin
                total++;
                if (stall !== 1'b1) begin
                    bad++;
                    $display("FAIL burst_stall: stall=%0b want 1", stall);
                end
            end
        end
        total++;
        if (peak != DEPTH) begin
            bad++;
            $display("FAIL burst_peak: peak=%0d want %0d", peak, DEPTH);
        end
    endtask

    task automatic test_collision();
        for (int c = 0; c < 4; c++) begin
            if (c == 0) drive(1, 7'd9, 128'd1, 1, 7'd9, 128'd2, 7'd9);
            else        drive(0, 0, 0, 0, 0, 0, 7'd9);
            #1;
            exp_f = model_fwd(fwd_ra);
            total++;
            if ({stall, fwd_hit, fwd_data} !== {mq.size() == DEPTH, exp_f}) begin
                bad++;
                $display("FAIL coll_comb c=%0d: stall/hit/fd=%0b/%0b/%h want %0b/%h",
                         c, stall, fwd_hit, fwd_data, mq.size() == DEPTH, exp_f);
            end
            total++;
            if ((c == 1 || c == 2) && {fwd_hit, fwd_data} !== {1'b1, 128'd2}) begin
                bad++;
                $display("FAIL coll_fwd c=%0d: hit=%0b fd=%h want 1 2", c, fwd_hit, fwd_data);
            end else if (c == 3 && fwd_hit !== 1'b0) begin
                bad++;
                $display("FAIL coll_drained: hit=%0b want 0", fwd_hit);
            end
            tick();
            total++;
            if ({regwrite, wa, wd, fifo_count, overflow_err} !== {m_rw, m_wa, m_wd, 3'(mq.size()), m_ovf}) begin
                bad++;
                $display("FAIL coll_seq c=%0d: rw=%0b wa=%0d wd=%h cnt=%0d want %0b %0d %h %0d",
                         c, regwrite, wa, wd, fifo_count, m_rw, m_wa, m_wd, mq.size());
            end
            total++;
            if (c == 0 && {regwrite, wa, wd} !== {1'b1, 7'd9, 128'd1}) begin
                bad++;
                $display("FAIL coll_first: rw=%0b wa=%0d wd=%h want 1 9 1", regwrite, wa, wd);
            end else if (c == 1 && {regwrite, wa, wd} !== {1'b1, 7'd9, 128'd2}) begin
                bad++;
                $display("FAIL coll_second: rw=%0b wa=%0d wd=%h want 1 9 2", regwrite, wa, wd);
            end
        end
    endtask

    task automatic test_wrap();
        for (int b = 0; b < 3; b++) begin
            for (int c = 0; c < 6; c++) begin
                if (c < 2) drive(1, 7'(40 + 4*b + 2*c), rnd128(), 1, 7'(41 + 4*b + 2*c), rnd128(),
                                 7'($urandom_range(40, 51)));
                else       drive(0, 0, 0, 0, 0, 0, 7'($urandom_range(40, 51)));
                #1;
                exp_f = model_fwd(fwd_ra);
                total++;
                if ({stall, fwd_hit, fwd_data} !== {mq.size() == DEPTH, exp_f}) begin
                    bad++;
                    $display("FAIL wrap_comb b=%0d c=%0d: stall/hit/fd=%0b/%0b/%h want %0b/%h",
                             b, c, stall, fwd_hit, fwd_data, mq.size() == DEPTH, exp_f);
                end
                tick();
                total++;
                if ({regwrite, wa, wd, fifo_count, overflow_err} !== {m_rw, m_wa, m_wd, 3'(mq.size()), m_ovf}) begin
                    bad++;
                    $display("FAIL wrap_seq b=%0d c=%0d: rw=%0b wa=%0d wd=%h cnt=%0d want %0b %0d %h %0d",
                             b, c, regwrite, wa, wd, fifo_count, m_rw, m_wa, m_wd, mq.size());
                end
            end
        end
        for (int r = 40; r < 52; r++) begin
            fwd_ra = 7'(r);
            #1;
            total++;
            if (fwd_hit !== 1'b0) begin
                bad++;
                $display("FAIL wrap_drained ra=%0d: hit=%0b want 0", r, fwd_hit);
            end
        end
    endtask

    task automatic test_overflow();
        for (int c = 0; c < 9; c++) begin
            if (c < 5) drive(1, 7'(60 + 2*c), rnd128(), 1, 7'(61 + 2*c), rnd128(), 7'($urandom_range(60, 69)));
            else       drive(0, 0, 0, 0, 0, 0, 7'($urandom_range(60, 69)));
            #1;
            exp_f = model_fwd(fwd_ra);
            total++;
            if ({stall, fwd_hit, fwd_data} !== {mq.size() == DEPTH, exp_f}) begin
                bad++;
                $display("FAIL ovf_comb c=%0d: stall/hit/fd=%0b/%0b/%h want %0b/%h",
                         c, stall, fwd_hit, fwd_data, mq.size() == DEPTH, exp_f);
            end
            tick();
            total++;
            if ({regwrite, wa, wd, fifo_count, overflow_err} !== {m_rw, m_wa, m_wd, 3'(mq.size()), m_ovf}) begin
                bad++;
                $display("FAIL ovf_seq c=%0d: rw=%0b wa=%0d wd=%h cnt=%0d ovf=%0b want %0b %0d %h %0d %0b",
                         c, regwrite, wa, wd, fifo_count, overflow_err, m_rw, m_wa, m_wd, mq.size(), m_ovf);
            end
            if (c >= 4) begin
                total++;
                if (overflow_err !== 1'b1 || fifo_count !== 3'(7 - c > 0 ? 7 - c : 0)) begin
                    bad++;
                    $display("FAIL ovf_sticky c=%0d: ovf=%0b cnt=%0d want 1 %0d",
                             c, overflow_err, fifo_count, 7 - c > 0 ? 7 - c : 0);
                end
            end
        end
    endtask

    task automatic test_random();
        logic ev, ov;
        for (int c = 0; c < 400; c++) begin
            ev = ($urandom_range(0, 9) < 6);
            ov = ($urandom_range(0, 9) < 6);
            if (mq.size() == DEPTH && $urandom_range(0, 19) != 0) begin
                ev = 1'b0;
                ov = 1'b0;
            end
            drive(ev, 7'($urandom_range(0, 15)), rnd128(), ov, 7'($urandom_range(0, 15)), rnd128(),
                  7'($urandom_range(0, 15)));
            #1;
            exp_f = model_fwd(fwd_ra);
            total++;
            if ({stall, fwd_hit, fwd_data} !== {mq.size() == DEPTH, exp_f}) begin
                bad++;
                $display("FAIL rand_comb c=%0d ra=%0d: stall/hit/fd=%0b/%0b/%h want %0b/%h",
                         c, fwd_ra, stall, fwd_hit, fwd_data, mq.size() == DEPTH, exp_f);
            end
            tick();
            total++;
            if ({regwrite, wa, wd, fifo_count, overflow_err} !== {m_rw, m_wa, m_wd, 3'(mq.size()), m_ovf}) begin
                bad++;
                $display("FAIL rand_seq c=%0d: rw=%0b wa=%0d wd=%h cnt=%0d ovf=%0b want %0b %0d %h %0d %0b",
                         c, regwrite, wa, wd, fifo_count, overflow_err, m_rw, m_wa, m_wd, mq.size(), m_ovf);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_dual_burst();
        test_collision();
        test_wrap();
        test_overflow();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
